// File: rtl/cmpr_pipe_if.sv
// cmpr_pipe_if: handshake bundle between a producer/consumer (master) and the cmpr_pipe comparator (slave).
//   in_valid/in_ready, i0, i1, op, pred : input transfer
//   out_valid/out_ready, o0, o0_enable  : output transfer
//   match_cnt                            : count of true, enabled results
interface cmpr_pipe_if #(parameter int WIDTH = 4);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic [2:0]       op;
    logic             pred;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] o0;
    logic             o0_enable;
    logic [15:0]      match_cnt;
    modport master (
        output in_valid, i0, i1, op, pred, out_ready,
        input  in_ready, out_valid, o0, o0_enable, match_cnt
    );
    modport slave (
        input  in_valid, i0, i1, op, pred, out_ready,
        output in_ready, out_valid, o0, o0_enable, match_cnt
    );
endinterface

// File: rtl/cmpr_pipe.sv
// cmpr_pipe: pipelined multi-mode WIDTH-bit comparator with valid/ready backpressure.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cmpr_pipe_if.slave (operands, op, pred in; o0, o0_enable, match_cnt out)
//   op codes   : 0 EQ, 1 NE, 2 LTU, 3 LEU, 4 LTS, 5 LES, 6 GTU, 7 GTS
//   Optional   : define CMPR_PIPE_MATCH_CNT_EN to enable the saturating match counter.
module cmpr_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input logic      clk,
    input logic      rst_n,
    cmpr_pipe_if.slave bus
);
    logic              eq, lt_u, lt_s, outcome, acc;
    logic [STAGES-1:0] v, r, p, load;
    logic [STAGES:0]   v_src, r_src, p_src;

    assign eq   = bus.i0 == bus.i1;
    assign lt_u = bus.i0 < bus.i1;
    assign lt_s = $signed(bus.i0) < $signed(bus.i1);

    always_comb begin
        outcome = bus.op == 3'd0 ? eq :
                  bus.op == 3'd1 ? !eq :
                  bus.op == 3'd2 ? lt_u :
                  bus.op == 3'd3 ? (lt_u || eq) :
                  bus.op == 3'd4 ? lt_s :
                  bus.op == 3'd5 ? (lt_s || eq) :
                  bus.op == 3'd6 ? !(lt_u || eq) : !(lt_s || eq);
    end

    // A stage loads when it, or any stage downstream of it, is empty, or the consumer accepts.
    always_comb begin
        load = '0;
        acc  = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc     = acc || !v[k];
            load[k] = acc;
        end
    end

    assign v_src = {v, bus.in_valid};
    assign r_src = {r, outcome};
    assign p_src = {p, bus.pred};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            r <= '0;
            p <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    v[k] <= v_src[k];
                    r[k] <= r_src[k];
                    p[k] <= p_src[k];
                end
            end
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = v[STAGES-1];
    assign bus.o0_enable = v[STAGES-1] && p[STAGES-1];
    assign bus.o0        = {{(WIDTH-1){1'b0}}, bus.o0_enable && r[STAGES-1]};

`ifdef CMPR_PIPE_MATCH_CNT_EN
    logic [15:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (bus.out_valid && bus.out_ready && bus.o0[0] && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
    end
    assign bus.match_cnt = cnt;
`else
    assign bus.match_cnt = '0;
`endif
endmodule
